mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline register. Consumes the registered ALU result, store data and memory/writeback control bits, issues word accesses on a ready/ack data-memory bus with arbitrary latency, stalls the pipeline while an access is outstanding, and presents registered results to the MEM/WB boundary. Non-memory instructions pass through with one cycle of latency and no stall.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: WAIT cycles allowed before the access is aborted (used only with the timeout feature). Legal range is 1..255.

Ports:
- clk  in  1  system clock; one clock; all state updates on its rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- alur_i  in  32  ALU result, i.e. the byte address for loads and stores
- wrdata_i  in  32  store data
- wmem_i  in  1  store request
- rmem_i  in  1  load request
- wreg_i  in  1  instruction writes the register file
- stall_o  out  1  hold EX/MEM and all upstream stages (combinational)
- mem_req_o  out  1  bus request; held until ack
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data; valid when mem_ack_i=1
- mem_ack_i  in  1  access completes this cycle
- wb_data_o  out  32  result to MEM/WB
- wb_wreg_o  out  1  register write enable to MEM/WB
- wb_valid_o  out  1  wb_data_o and wb_wreg_o hold a new result
- err_o  out  1  single-cycle error pulse

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op (wmem_i=rmem_i=0):
  - stall_o=0.
  - At the edge: wb_data_o<=alur_i, wb_wreg_o<=wreg_i, wb_valid_o<=1.
- IDLE, memory op:
  - stall_o=1.
  - At the edge: capture the address, data, write flag and wreg_i into internal registers; wb_valid_o<=0; go to WAIT.
- Both wmem_i and rmem_i high: the store wins. err_o pulses for the capture cycle.
- WAIT:
  - stall_o=1, mem_req_o=1; mem_we_o, mem_addr_o and mem_wdata_o come from the captured registers.
  - On mem_ack_i=1, at the edge:
    - load: wb_data_o<=mem_rdata_i, wb_wreg_o<=captured wreg.
    - store: wb_data_o<=captured address, wb_wreg_o<=0.
    - Both cases: wb_valid_o<=1, go to DONE.
- DONE:
  - stall_o=0 and the inputs are ignored, because they still show the consumed op.
  - At the edge: wb_valid_o<=0, go to IDLE.
  - Each memory op therefore costs one bubble cycle.
- mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered and are 0 outside WAIT.
- Address bits [1:0] are ignored.
- Reset values: state=IDLE; stall_o=0 (follows from IDLE with reset-time inputs); mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; wb_data_o=0, wb_wreg_o=0, wb_valid_o=0; err_o=0; timeout counter=0.
- Reset asserted mid-access: everything returns to reset values immediately. mem_req_o drops without waiting for an ack, and any later ack is ignored in IDLE.

## Timing
- Non-memory op: result on wb_* one cycle after it is presented. Throughput is 1 per cycle.
- Memory op with ack after k WAIT cycles (k>=1, ack sampled in the k-th WAIT cycle):
  - stall_o is high for k+1 cycles.
  - wb_valid_o rises 1+k cycles after the op is presented.
  - The next instruction is accepted 2+k cycles after it. Minimum latency is 3 cycles from presentation to the next instruction being accepted.
- mem_ack_i outside WAIT has no effect.
- Upstream must hold all *_i inputs stable while stall_o=1.

## Configuration
- MEM_ACC_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without an ack.
  - When the count reaches TIMEOUT_CYCLES with no ack, at that edge: mem_req_o<=0, err_o pulses 1, wb_data_o<=32'hDEADBEEF, wb_wreg_o<=0, wb_valid_o<=1, go to DONE.
  - An ack arriving in the same cycle as the timeout takes priority and completes normally.
- MEM_ACC_TIMEOUT_EN undefined: no counter is built and WAIT lasts until an ack arrives. err_o reports only the simultaneous wmem_i/rmem_i case.

## Test plan
- ALU op alur_i=0x00000042, wreg_i=1 → next cycle wb_data_o=0x42, wb_wreg_o=1, wb_valid_o=1, stall_o never high.
- Load rmem_i=1, alur_i=0x00001007, ack on the first WAIT cycle with rdata=0xCAFEF00D → mem_addr_o=0x00001004, mem_we_o=0, stall_o high for 2 cycles, wb_data_o=0xCAFEF00D, wb_wreg_o=1.
- Store wmem_i=1, wrdata_i=0x12345678, alur_i=0x20, ack delayed 5 cycles → mem_we_o=1, mem_wdata_o=0x12345678 stable for all 5 cycles, stall_o high for 6 cycles, wb_wreg_o=0.
- wmem_i=rmem_i=1 → err_o pulses in the capture cycle and a write is issued.
- With MEM_ACC_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → mem_req_o drops after 4 WAIT cycles, err_o=1 for 1 cycle, wb_data_o=0xDEADBEEF, wb_valid_o=1.
- rst driven low for one cycle during WAIT → mem_req_o=0 and stall_o=0 asynchronously; a later mem_ack_i=1 produces no wb_valid_o.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the memory (slave).
// Word accesses with a ready/ack handshake: the request is held until ack.
interface mem_access_unit_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    output mem_ack_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access controller behind the EX/MEM register.
// Non-memory ops pass to MEM/WB in one cycle; loads/stores are captured, issued
// on the data bus, and the pipeline is stalled until the ack, then a one-cycle
// DONE bubble follows while upstream still shows the consumed op.
// Optional feature: define MEM_ACC_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES WAIT cycles without ack (result 32'hDEADBEEF, err_o pulse).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alur_i,
  input  logic [31:0]       wrdata_i,
  input  logic              wmem_i,
  input  logic              rmem_i,
  input  logic              wreg_i,
  output logic              stall_o,
  mem_access_unit_if.master mem_bus,
  output logic [31:0]       wb_data_o,
  output logic              wb_wreg_o,
  output logic              wb_valid_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wreg_cap_q, wreg_cap_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic        wb_valid_q, wb_valid_d;
  logic        err_q, err_d;
  logic        mem_op;
  logic        timeout;

  assign mem_op = wmem_i | rmem_i;

`ifdef MEM_ACC_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // WAIT-cycle counter; held at zero while idle so it starts from 0 on WAIT entry
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if ((state_q == StWait) && !mem_bus.mem_ack_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle ack wins
  assign timeout = (state_q == StWait) && !mem_bus.mem_ack_i &&
                   (cnt_q == TimeoutLim - 8'd1);
`else
  logic unused_timeout_lim;
  assign unused_timeout_lim = ^TimeoutLim;
  assign timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mem_op) state_d = StWait;
      StWait: if (mem_bus.mem_ack_i || timeout) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM combinational outputs; gated by reset so a held op cannot stall during reset
  always_comb begin
    stall_o = 1'b0;
    err_o   = err_q;
    if (rst) begin
      unique case (state_q)
        StIdle: begin
          stall_o = mem_op;
          // Conflicting request flags flagged in the cycle the op is captured
          err_o   = err_q | (wmem_i & rmem_i);
        end
        StWait:  stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  // Datapath next-state: capture, bus drive and MEM/WB result
  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wreg_cap_d = wreg_cap_q;
    wb_data_d  = wb_data_q;
    wb_wreg_d  = wb_wreg_q;
    wb_valid_d = wb_valid_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          // Bus registers double as the capture registers for the access
          req_d      = 1'b1;
          we_d       = wmem_i;
          addr_d     = {alur_i[31:2], 2'b00};
          wdata_d    = wrdata_i;
          wreg_cap_d = wreg_i;
          wb_valid_d = 1'b0;
        end else begin
          wb_data_d  = alur_i;
          wb_wreg_d  = wreg_i;
          wb_valid_d = 1'b1;
        end
      end
      StWait: begin
        if (mem_bus.mem_ack_i || timeout) begin
          req_d      = 1'b0;
          we_d       = 1'b0;
          addr_d     = '0;
          wdata_d    = '0;
          wb_valid_d = 1'b1;
          if (mem_bus.mem_ack_i) begin
            wb_data_d = we_q ? addr_q : mem_bus.mem_rdata_i;
            wb_wreg_d = we_q ? 1'b0 : wreg_cap_q;
          end else begin
            wb_data_d = 32'hDEAD_BEEF;
            wb_wreg_d = 1'b0;
            err_d     = 1'b1;
          end
        end
      end
      StDone: wb_valid_d = 1'b0;
      default: wb_valid_d = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wreg_cap_q <= 1'b0;
      wb_data_q  <= '0;
      wb_wreg_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wreg_cap_q <= wreg_cap_d;
      wb_data_q  <= wb_data_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  assign mem_bus.mem_req_o   = req_q;
  assign mem_bus.mem_we_o    = we_q;
  assign mem_bus.mem_addr_o  = addr_q;
  assign mem_bus.mem_wdata_o = wdata_q;
  assign wb_data_o           = wb_data_q;
  assign wb_wreg_o           = wb_wreg_q;
  assign wb_valid_o          = wb_valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: each op is described by its kind and ack
// delay; the expected per-cycle outputs follow from the timing rules (stall for
// k+1 cycles, request during k WAIT cycles, one DONE bubble) and are checked
// every cycle, with literal spot checks after each op.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] alur_i;
  logic [31:0] wrdata_i;
  logic        wmem_i;
  logic        rmem_i;
  logic        wreg_i;
  logic        stall_o;
  logic [31:0] wb_data_o;
  logic        wb_wreg_o;
  logic        wb_valid_o;
  logic        err_o;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alur_i    (alur_i),
    .wrdata_i  (wrdata_i),
    .wmem_i    (wmem_i),
    .rmem_i    (rmem_i),
    .wreg_i    (wreg_i),
    .stall_o   (stall_o),
    .mem_bus   (bus),
    .wb_data_o (wb_data_o),
    .wb_wreg_o (wb_wreg_o),
    .wb_valid_o(wb_valid_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model of what MEM/WB currently shows
  logic [31:0] m_wb_data;
  logic        m_wb_wreg;
  logic        m_wb_valid;

  // Per-cycle expectations
  logic        chk_en = 1'b0;
  logic        e_stall, e_err, e_req, e_we;
  logic [31:0] e_addr, e_wdata;

  // Observations gathered during the last op
  int          obs_stall, obs_req, obs_err;
  logic [31:0] obs_addr, obs_wdata, obs_wb_data;
  logic        obs_we, obs_wb_wreg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_o", 32'(stall_o), 32'(e_stall));
      chk("err_o", 32'(err_o), 32'(e_err));
      chk("mem_req_o", 32'(bus.mem_req_o), 32'(e_req));
      chk("mem_we_o", 32'(bus.mem_we_o), 32'(e_we));
      chk("mem_addr_o", bus.mem_addr_o, e_addr);
      chk("mem_wdata_o", bus.mem_wdata_o, e_wdata);
      chk("wb_valid_o", 32'(wb_valid_o), 32'(m_wb_valid));
      chk("wb_data_o", wb_data_o, m_wb_data);
      chk("wb_wreg_o", 32'(wb_wreg_o), 32'(m_wb_wreg));
    end
  end

  task automatic set_exp(input logic stall, input logic err, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    e_stall = stall;
    e_err   = err;
    e_req   = req;
    e_we    = we;
    e_addr  = addr;
    e_wdata = wdata;
  endtask

  // One clock cycle: observe at the falling edge, return just after the rising edge
  task automatic cyc();
    @(negedge clk);
    if (stall_o) obs_stall++;
    if (err_o) obs_err++;
    if (bus.mem_req_o) begin
      obs_req++;
      obs_addr  = bus.mem_addr_o;
      obs_we    = bus.mem_we_o;
      obs_wdata = bus.mem_wdata_o;
    end
    if (wb_valid_o) begin
      obs_wb_data = wb_data_o;
      obs_wb_wreg = wb_wreg_o;
    end
    @(posedge clk);
    #1;
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 both flags; k: WAIT cycle carrying the ack
  task automatic run_op(input int kind, input logic [31:0] alur, input logic [31:0] wd,
                        input logic wreg, input int k, input logic [31:0] rdata,
                        input logic stray_ack);
    logic        is_mem = (kind != 0);
    logic        is_st  = (kind >= 2);
    logic [31:0] waddr  = {alur[31:2], 2'b00};
    logic        to     = 1'b0;
    int          kk     = k;
`ifdef MEM_ACC_TIMEOUT_EN
    if (k > int'(TO)) begin
      to = 1'b1;
      kk = int'(TO);
    end
`endif
    obs_stall = 0; obs_req = 0; obs_err = 0;
    obs_addr = '0; obs_wdata = '0; obs_we = 1'b0; obs_wb_data = '0; obs_wb_wreg = 1'b0;
    chk_en = 1'b1;
    alur_i   = alur;
    wrdata_i = wd;
    wmem_i   = is_st;
    rmem_i   = (kind == 1) || (kind == 3);
    wreg_i   = wreg;
    bus.mem_ack_i   = stray_ack;
    bus.mem_rdata_i = rdata;
    set_exp(is_mem, kind == 3, 1'b0, 1'b0, '0, '0);
    cyc();
    if (!is_mem) begin
      m_wb_data = alur; m_wb_wreg = wreg; m_wb_valid = 1'b1;
      return;
    end
    m_wb_valid = 1'b0;
    for (int w = 1; w <= kk; w++) begin
      bus.mem_ack_i = (w == k);
      set_exp(1'b1, 1'b0, 1'b1, is_st, waddr, wd);
      cyc();
    end
    m_wb_valid = 1'b1;
    if (to) begin
      m_wb_data = 32'hDEAD_BEEF; m_wb_wreg = 1'b0;
    end else if (is_st) begin
      m_wb_data = waddr; m_wb_wreg = 1'b0;
    end else begin
      m_wb_data = rdata; m_wb_wreg = wreg;
    end
    // DONE bubble: inputs still show the consumed op and must be ignored
    bus.mem_ack_i = stray_ack;
    set_exp(1'b0, to, 1'b0, 1'b0, '0, '0);
    cyc();
    m_wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    alur_i = '0; wrdata_i = '0; wmem_i = 1'b0; rmem_i = 1'b0; wreg_i = 1'b0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    m_wb_data = '0; m_wb_wreg = 1'b0; m_wb_valid = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall_o", 32'(stall_o), 32'd0);
    chk("reset mem_req_o", 32'(bus.mem_req_o), 32'd0);
    chk("reset mem_addr_o", bus.mem_addr_o, 32'd0);
    chk("reset wb_valid_o", 32'(wb_valid_o), 32'd0);
    chk("reset wb_data_o", wb_data_o, 32'd0);
    chk("reset err_o", 32'(err_o), 32'd0);
    rst = 1'b1;

    // ALU pass-through
    run_op(0, 32'h0000_0042, 32'h0, 1'b1, 0, 32'h0, 1'b0);
    chk("alu wb_data", wb_data_o, 32'h0000_0042);
    chk("alu wb_wreg", 32'(wb_wreg_o), 32'd1);
    chk("alu wb_valid", 32'(wb_valid_o), 32'd1);
    chk("alu stall cycles", obs_stall, 32'd0);
    run_op(0, 32'hFFFF_0000, 32'h0, 1'b0, 0, 32'h1111_1111, 1'b1);

    // Load, ack in first WAIT cycle
    run_op(1, 32'h0000_1007, 32'h0, 1'b1, 1, 32'hCAFE_F00D, 1'b0);
    chk("load addr", obs_addr, 32'h0000_1004);
    chk("load we", 32'(obs_we), 32'd0);
    chk("load stall cycles", obs_stall, 32'd2);
    chk("load wb_data", obs_wb_data, 32'hCAFE_F00D);
    chk("load wb_wreg", 32'(obs_wb_wreg), 32'd1);

    // Store, ack after 5 WAIT cycles
    run_op(2, 32'h0000_0020, 32'h1234_5678, 1'b1, 5, 32'h0, 1'b0);
    chk("store we", 32'(obs_we), 32'd1);
    chk("store wdata", obs_wdata, 32'h1234_5678);
    chk("store req cycles", obs_req, 32'd5);
    chk("store stall cycles", obs_stall, 32'd6);
    chk("store wb_wreg", 32'(obs_wb_wreg), 32'd0);
    chk("store wb_data", obs_wb_data, 32'h0000_0020);

    run_op(1, 32'h8000_0002, 32'h0, 1'b0, 3, 32'h0BAD_C0DE, 1'b1);
    chk("load2 addr", obs_addr, 32'h8000_0000);
    run_op(0, 32'h0000_0007, 32'h0, 1'b1, 0, 32'h0, 1'b0);

    // Both flags: store wins, err pulse in capture cycle
    run_op(3, 32'h0000_0044, 32'hA5A5_A5A5, 1'b1, 2, 32'h0, 1'b0);
    chk("both err cycles", obs_err, 32'd1);
    chk("both we", 32'(obs_we), 32'd1);
    chk("both wb_wreg", 32'(obs_wb_wreg), 32'd0);

    // Ack on the 4th WAIT cycle (coincides with the timeout point when enabled)
    run_op(1, 32'h0000_0300, 32'h0, 1'b1, 4, 32'h0123_4567, 1'b0);
    chk("late ack wb_data", obs_wb_data, 32'h0123_4567);
    chk("late ack err cycles", obs_err, 32'd0);

`ifdef MEM_ACC_TIMEOUT_EN
    run_op(1, 32'h0000_0100, 32'h0, 1'b1, 100, 32'h0, 1'b0);
    chk("timeout req cycles", obs_req, 32'd4);
    chk("timeout err cycles", obs_err, 32'd1);
    chk("timeout wb_data", obs_wb_data, 32'hDEAD_BEEF);
    chk("timeout wb_wreg", 32'(obs_wb_wreg), 32'd0);
`endif

    // Reset in the middle of a WAIT
    chk_en = 1'b0;
    alur_i = 32'h0000_0300; rmem_i = 1'b1; wmem_i = 1'b0; wreg_i = 1'b1;
    bus.mem_ack_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset mem_req_o", 32'(bus.mem_req_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("async reset mem_req_o", 32'(bus.mem_req_o), 32'd0);
    chk("async reset stall_o", 32'(stall_o), 32'd0);
    chk("async reset wb_data_o", wb_data_o, 32'd0);
    rmem_i = 1'b0; alur_i = 32'h0000_0077; wreg_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_wb_data = '0; m_wb_wreg = 1'b0; m_wb_valid = 1'b0;
    run_op(0, 32'h0000_0077, 32'h0, 1'b0, 0, 32'h5A5A_5A5A, 1'b1);
    chk("post-reset ack wb_data", wb_data_o, 32'h0000_0077);
    chk("post-reset mem_req_o", 32'(bus.mem_req_o), 32'd0);
    run_op(0, 32'h0000_0001, 32'h0, 1'b1, 0, 32'h0, 1'b0);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
